// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_VEC_BUSY = 1'b1;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Winning stall/flush reason for the current cycle, kept visible for debug.
  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_RESET    = 3'd1,
    CAUSE_MEM      = 3'd2,
    CAUSE_VEC      = 3'd3,
    CAUSE_BRANCH   = 3'd4,
    CAUSE_LOAD_USE = 3'd5
  } stall_cause_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage scalar+vector pipeline: memory wait,
// vector occupancy, taken-branch flush and load-use interlock, in that priority.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned VLAT    = 4,
  parameter int unsigned MEM_TMO = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             ifid_uses_rs2_i,
  input  logic             branch_taken_i,
  input  logic             vec_issue_i,
  input  logic             exmem_memreq_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_hold_o,
  output logic             idex_flush_o,
  output logic             exmem_hold_o,
  output logic             exmem_bubble_o,
  output logic             memwb_bubble_o,
  output logic             vec_busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  // The entry cycle is the first of VLAT-1 stall cycles, so the counter only
  // has to hold the remaining VLAT-2.
  localparam int unsigned VCNT_W = (VLAT > 2) ? $clog2(VLAT) : 1;
  localparam int unsigned WCNT_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;

  logic              state_q, state_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              vec_busy_q;
  logic              mem_stall_c;
  logic              load_use_c;
  stall_cause_e      cause_c;

  assign mem_stall_c = exmem_memreq_i && !mem_ready_i;

  assign load_use_c = idex_memread_i && (idex_rd_i != REG_X0) &&
                      ((idex_rd_i == ifid_rs1_i) ||
                       (ifid_uses_rs2_i && (idex_rd_i == ifid_rs2_i)));

  always_ff @(posedge clk_i) begin
    if (!start_i) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Next state, vector countdown and the winning cause for this cycle.
  always_comb begin
    state_d = state_q;
    vcnt_d  = vcnt_q;
    cause_c = CAUSE_NONE;
    if (!start_i) begin
      cause_c = CAUSE_RESET;
    end else if (mem_stall_c) begin
      cause_c = CAUSE_MEM;
    end else if (state_q == ST_VEC_BUSY) begin
      if (vcnt_q != '0) begin
        vcnt_d  = vcnt_q - VCNT_W'(1);
        cause_c = CAUSE_VEC;
      end else begin
        state_d = ST_RUN;
        if (branch_taken_i)  cause_c = CAUSE_BRANCH;
        else if (load_use_c) cause_c = CAUSE_LOAD_USE;
      end
    end else if (vec_issue_i && (VLAT > 1)) begin
      state_d = ST_VEC_BUSY;
      vcnt_d  = VCNT_W'(VLAT - 2);
      cause_c = CAUSE_VEC;
    end else if (branch_taken_i) begin
      cause_c = CAUSE_BRANCH;
    end else if (load_use_c) begin
      cause_c = CAUSE_LOAD_USE;
    end
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_hold_o    = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_hold_o   = 1'b0;
    exmem_bubble_o = 1'b0;
    memwb_bubble_o = 1'b0;
    case (cause_c)
      CAUSE_RESET: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
      end
      CAUSE_MEM: begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_hold_o    = 1'b1;
        exmem_hold_o   = 1'b1;
        memwb_bubble_o = 1'b1;
      end
      CAUSE_VEC: begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_hold_o    = 1'b1;
        exmem_bubble_o = 1'b1;
      end
      CAUSE_BRANCH: begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
      end
      CAUSE_LOAD_USE: begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        idex_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Consecutive memory wait cycles; the timeout flag is sticky until reset.
  always_comb begin
    wcnt_d = '0;
    err_d  = err_q;
    if (mem_stall_c) begin
      wcnt_d = (wcnt_q == WCNT_W'(MEM_TMO)) ? wcnt_q : wcnt_q + WCNT_W'(1);
      if (wcnt_d == WCNT_W'(MEM_TMO)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      vcnt_q     <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      vec_busy_q <= 1'b0;
    end else begin
      vcnt_q     <= vcnt_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      vec_busy_q <= (state_d == ST_VEC_BUSY);
    end
  end

  assign vec_busy_o = vec_busy_q;
  assign err_o      = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (!start_i),
    .inc_i (start_i && !pc_write_o),
    .cnt_o (stall_cycles_o)
  );

endmodule
